uart_frame_ctrl: RTL and testbench

//  Sequences the byte stream from the UART receiver into command frames for the
//  LCD display controller. Tracks receiver busy to capture each byte, then parses

---
 rtl/uart_frame_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_uart_frame_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_ctrl.sv
// rtl/uart_frame_ctrl.sv - UART byte stream to LCD command frame parser with hold buffer
// Frame format: 0xA5 | CMD | LEN | payload[LEN] | SUM (8-bit sum of CMD+LEN+payload).
module uart_frame_ctrl #(
   parameter int MAX_LEN     = 16,
   parameter int TIMEOUT_CYC = 500000,
   localparam int AW         = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_busy,
   input  logic [7:0]    rx_data,
   output logic          frame_valid,
   input  logic          frame_ack,
   output logic [7:0]    frame_cmd,
   output logic [7:0]    frame_len,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data,
   output logic          busy,
   output logic          err_sum,
   output logic          err_len,
   output logic          err_timeout,
   output logic          err_overrun
);

   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [7:0] SYNC = 8'hA5;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CMD  = 3'd1,
      S_LEN  = 3'd2,
      S_DATA = 3'd3,
      S_SUM  = 3'd4,
      S_HOLD = 3'd5
   } state_t;

   state_t        r_state, w_state;
   logic          r_busy_d;
   logic          r_byte_stb;
   logic [7:0]    r_byte;
   logic [7:0]    r_cmd, w_cmd;
   logic [7:0]    r_len, w_len;
   logic [7:0]    r_sum, w_sum;
   logic [7:0]    r_idx, w_idx;
   logic [TW-1:0] r_tmo, w_tmo;
   logic          r_err_sum, w_err_sum;
   logic          r_err_len, w_err_len;
   logic          r_err_tmo, w_err_tmo;
   logic          r_err_ovr, w_err_ovr;
   logic          w_we;
   logic          w_fall;
   logic          w_parsing;
   logic [7:0]    r_buf [MAX_LEN];

   // A byte is complete when the receiver drops busy; capture it one clock later.
   assign w_fall = r_busy_d & ~rx_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy_d   <= 1'b0;
         r_byte_stb <= 1'b0;
         r_byte     <= 8'h00;
      end else begin
         r_busy_d   <= rx_busy;
         r_byte_stb <= w_fall;
         if (w_fall)
            r_byte <= rx_data;
      end
   end

   assign w_parsing = (r_state == S_CMD) || (r_state == S_LEN) ||
                      (r_state == S_DATA) || (r_state == S_SUM);

   always_comb begin
      w_state   = r_state;
      w_cmd     = r_cmd;
      w_len     = r_len;
      w_sum     = r_sum;
      w_idx     = r_idx;
      w_tmo     = r_tmo;
      w_we      = 1'b0;
      w_err_sum = 1'b0;
      w_err_len = 1'b0;
      w_err_tmo = 1'b0;
      w_err_ovr = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_tmo = '0;
            if (r_byte_stb && r_byte == SYNC)
               w_state = S_CMD;
         end
         S_CMD: begin
            if (r_byte_stb) begin
               w_cmd   = r_byte;
               w_sum   = r_byte;
               w_state = S_LEN;
            end
         end
         S_LEN: begin
            if (r_byte_stb) begin
               if (r_byte > 8'(MAX_LEN)) begin
                  w_err_len = 1'b1;
                  w_state   = S_IDLE;
               end else begin
                  w_len   = r_byte;
                  w_sum   = r_sum + r_byte;
                  w_idx   = 8'h00;
                  w_state = (r_byte == 8'h00) ? S_SUM : S_DATA;
               end
            end
         end
         S_DATA: begin
            if (r_byte_stb) begin
               w_we  = 1'b1;
               w_sum = r_sum + r_byte;
               w_idx = r_idx + 8'h01;
               if (r_idx == r_len - 8'h01)
                  w_state = S_SUM;
            end
         end
         S_SUM: begin
            if (r_byte_stb) begin
               if (r_byte == r_sum) begin
                  w_state = S_HOLD;
               end else begin
                  w_err_sum = 1'b1;
                  w_state   = S_IDLE;
               end
            end
         end
         S_HOLD: begin
            w_tmo     = '0;
            w_err_ovr = r_byte_stb;
            if (frame_ack)
               w_state = S_IDLE;
         end
         default: w_state = S_IDLE;
      endcase

      // A byte arriving on the expiry clock takes priority over the timeout.
      if (w_parsing) begin
         if (r_byte_stb) begin
            w_tmo = '0;
         end else if (r_tmo == TW'(TIMEOUT_CYC - 1)) begin
            w_tmo     = '0;
            w_err_tmo = 1'b1;
            w_state   = S_IDLE;
         end else begin
            w_tmo = r_tmo + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_cmd     <= 8'h00;
         r_len     <= 8'h00;
         r_sum     <= 8'h00;
         r_idx     <= 8'h00;
         r_tmo     <= '0;
         r_err_sum <= 1'b0;
         r_err_len <= 1'b0;
         r_err_tmo <= 1'b0;
         r_err_ovr <= 1'b0;
      end else begin
         r_state   <= w_state;
         r_cmd     <= w_cmd;
         r_len     <= w_len;
         r_sum     <= w_sum;
         r_idx     <= w_idx;
         r_tmo     <= w_tmo;
         r_err_sum <= w_err_sum;
         r_err_len <= w_err_len;
         r_err_tmo <= w_err_tmo;
         r_err_ovr <= w_err_ovr;
      end
   end

   always_ff @(posedge clk) begin
      if (w_we)
         r_buf[r_idx[AW-1:0]] <= r_byte;
   end

   assign frame_valid = (r_state == S_HOLD);
   assign busy        = w_parsing;
   assign frame_cmd   = r_cmd;
   assign frame_len   = r_len;
   assign rd_data     = r_buf[rd_addr];
   assign err_sum     = r_err_sum;
   assign err_len     = r_err_len;
   assign err_timeout = r_err_tmo;
   assign err_overrun = r_err_ovr;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// tb/tb_uart_frame_ctrl.sv - self-checking bench for uart_frame_ctrl with a frame-level model
module tb_uart_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 100;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_busy = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       frame_ack = 1'b0;
   logic [3:0] rd_addr = 4'd0;
   logic       frame_valid, busy, err_sum, err_len, err_timeout, err_overrun;
   logic [7:0] frame_cmd, frame_len, rd_data;

   int n_chk = 0;
   int n_err = 0;
   int n_sum = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

   uart_frame_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_busy(rx_busy), .rx_data(rx_data),
      .frame_valid(frame_valid), .frame_ack(frame_ack),
      .frame_cmd(frame_cmd), .frame_len(frame_len),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy),
      .err_sum(err_sum), .err_len(err_len),
      .err_timeout(err_timeout), .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rst_n) begin
         if (err_sum)     n_sum++;
         if (err_len)     n_len++;
         if (err_timeout) n_tmo++;
         if (err_overrun) n_ovr++;
      end
   end

   function automatic logic [7:0] frame_sum(input logic [7:0] cmd, input int len,
                                            input logic [7:0] p [MAX_LEN]);
      int s = int'(cmd) + len;
      for (int i = 0; i < len; i++) s += int'(p[i]);
      return 8'(s % 256);
   endfunction

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk) rx_busy = 1'b1;
      repeat (3) @(negedge clk);
      rx_data = b;
      rx_busy = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] cmd, input int len,
                             input logic [7:0] p [MAX_LEN], input logic [7:0] s);
      send_byte(8'hA5);
      send_byte(cmd);
      send_byte(8'(len));
      for (int i = 0; i < len; i++) send_byte(p[i]);
      send_byte(s);
   endtask

   task automatic do_ack;
      @(negedge clk) frame_ack = 1'b1;
      @(negedge clk) frame_ack = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      n_chk++;
      if ({frame_valid, busy, err_sum, err_len, err_timeout, err_overrun} !== 6'b0 ||
          frame_cmd !== 8'h00 || frame_len !== 8'h00) begin
         n_err++;
         $display("FAIL reset_outputs: valid=%b busy=%b cmd=%h len=%h required all 0",
                  frame_valid, busy, frame_cmd, frame_len);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_good_frame;
      logic [7:0] p [MAX_LEN];
      logic [7:0] exp_d [3];
      exp_d = '{8'h11, 8'h22, 8'h33};
      p = '{default: 8'h00};
      for (int i = 0; i < 3; i++) p[i] = exp_d[i];
      send_frame(8'h01, 3, p, 8'h6A);
      n_chk++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h01 || frame_len !== 8'h03) begin
         n_err++;
         $display("FAIL good_frame_hdr: valid=%b cmd=%h len=%h required 1 01 03",
                  frame_valid, frame_cmd, frame_len);
      end
      for (int i = 0; i < 3; i++) begin
         rd_addr = 4'(i);
         #1;
         n_chk++;
         if (rd_data !== exp_d[i]) begin
            n_err++;
            $display("FAIL good_frame_data[%0d]: got %h required %h", i, rd_data, exp_d[i]);
         end
      end
      do_ack();
      n_chk++;
      if (frame_valid !== 1'b0) begin
         n_err++;
         $display("FAIL ack_release: valid=%b required 0", frame_valid);
      end
   endtask

   task automatic test_bad_sum;
      logic [7:0] p [MAX_LEN];
      int s0 = n_sum;
      p = '{default: 8'h00};
      p[0] = 8'h11; p[1] = 8'h22; p[2] = 8'h33;
      send_frame(8'h01, 3, p, 8'h6B);
      n_chk++;
      if (n_sum !== s0 + 1 || frame_valid !== 1'b0) begin
         n_err++;
         $display("FAIL bad_sum: err_sum pulses=%0d valid=%b required 1 and 0",
                  n_sum - s0, frame_valid);
      end
      p[0] = 8'h40;
      send_frame(8'h07, 1, p, 8'h48);
      n_chk++;
      if (frame_valid !== 1'b1 || frame_cmd !== 8'h07) begin
         n_err++;
         $display("FAIL after_bad_sum: valid=%b cmd=%h required 1 07", frame_valid, frame_cmd);
      end
      do_ack();
   endtask

   task automatic test_zero_len;
      logic [7:0] p [MAX_LEN];
      p = '{default: 8'h00};
      send_byte(8'h7E);
      send_frame(8'h02, 0, p, 8'h02);
      n_chk++;
      if (frame_valid !== 1'b1 || frame_len !== 8'h00 || frame_cmd !== 8'h02) begin
         n_err++;
         $display("FAIL zero_len: valid=%b cmd=%h len=%h required 1 02 00",
                  frame_valid, frame_cmd, frame_len);
      end
      do_ack();
   endtask

   task automatic test_bad_len;
      logic [7:0] p [MAX_LEN];
      int l0 = n_len;
      p = '{default: 8'h00};
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h11);
      n_chk++;
      if (n_len !== l0 + 1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL bad_len: err_len pulses=%0d busy=%b required 1 and 0", n_len - l0, busy);
      end
      p[0] = 8'h05; p[15] = 8'hF0;
      send_frame(8'h03, 16, p, frame_sum(8'h03, 16, p));
      n_chk++;
      if (frame_valid !== 1'b1 || frame_len !== 8'd16) begin
         n_err++;
         $display("FAIL max_len_frame: valid=%b len=%h required 1 10", frame_valid, frame_len);
      end
      rd_addr = 4'd15;
      #1;
      n_chk++;
      if (rd_data !== 8'hF0) begin
         n_err++;
         $display("FAIL max_len_last: got %h required f0", rd_data);
      end
      do_ack();
   endtask

   task automatic test_timeout;
      int t0 = n_tmo;
      int cyc = 0;
      send_byte(8'hA5);
      send_byte(8'h01);
      n_chk++;
      if (busy !== 1'b1) begin
         n_err++;
         $display("FAIL timeout_busy_before: busy=%b required 1", busy);
      end
      while (n_tmo == t0 && cyc < 3 * TMO) begin
         @(negedge clk);
         cyc++;
      end
      n_chk++;
      if (n_tmo !== t0 + 1 || cyc < TMO - 10 || cyc > TMO) begin
         n_err++;
         $display("FAIL timeout_pulse: pulses=%0d after %0d clks required 1 within %0d..%0d",
                  n_tmo - t0, cyc, TMO - 10, TMO);
      end
      n_chk++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL timeout_busy_after: busy=%b required 0", busy);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] p [MAX_LEN];
      int o0 = n_ovr;
      p = '{default: 8'h00};
      p[0] = 8'hDE; p[1] = 8'hAD;
      send_frame(8'h09, 2, p, frame_sum(8'h09, 2, p));
      send_byte(8'hA5);
      rd_addr = 4'd1;
      #1;
      n_chk++;
      if (n_ovr !== o0 + 1 || frame_valid !== 1'b1 || frame_cmd !== 8'h09 ||
          frame_len !== 8'h02 || rd_data !== 8'hAD) begin
         n_err++;
         $display("FAIL overrun: pulses=%0d valid=%b cmd=%h len=%h d1=%h required 1 1 09 02 ad",
                  n_ovr - o0, frame_valid, frame_cmd, frame_len, rd_data);
      end
      do_ack();
   endtask

   task automatic test_reset_mid;
      send_byte(8'hA5);
      send_byte(8'h01);
      send_byte(8'h05);
      send_byte(8'h11);
      rst_n = 1'b0;
      #1;
      n_chk++;
      if ({frame_valid, busy, err_sum, err_len, err_timeout, err_overrun} !== 6'b0 ||
          frame_cmd !== 8'h00 || frame_len !== 8'h00) begin
         n_err++;
         $display("FAIL reset_mid: valid=%b busy=%b cmd=%h len=%h required all 0",
                  frame_valid, busy, frame_cmd, frame_len);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_byte(8'h22);
      n_chk++;
      if (busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_idle: busy=%b required 0", busy);
      end
   endtask

   task automatic test_random;
      logic [7:0] p [MAX_LEN];
      logic [7:0] cmd, good, sent;
      int len, s0;
      bit bad;
      for (int f = 0; f < 20; f++) begin
         cmd = 8'($urandom);
         len = $urandom_range(0, MAX_LEN);
         for (int i = 0; i < MAX_LEN; i++) p[i] = 8'($urandom);
         good = frame_sum(cmd, len, p);
         bad  = ($urandom_range(0, 3) == 0);
         sent = bad ? (good ^ 8'($urandom_range(1, 255))) : good;
         if ($urandom_range(0, 1) == 1) send_byte(8'($urandom_range(0, 8'hA4)));
         s0 = n_sum;
         send_frame(cmd, len, p, sent);
         n_chk++;
         if (frame_valid !== !bad || n_sum !== s0 + int'(bad)) begin
            n_err++;
            $display("FAIL rand_frame%0d: valid=%b sum_err=%0d required %b %0d",
                     f, frame_valid, n_sum - s0, !bad, int'(bad));
         end
         if (!bad) begin
            n_chk++;
            if (frame_cmd !== cmd || frame_len !== 8'(len)) begin
               n_err++;
               $display("FAIL rand_hdr%0d: cmd=%h len=%h required %h %h",
                        f, frame_cmd, frame_len, cmd, 8'(len));
            end
            for (int i = 0; i < len; i++) begin
               rd_addr = 4'(i);
               #1;
               n_chk++;
               if (rd_data !== p[i]) begin
                  n_err++;
                  $display("FAIL rand_data%0d[%0d]: got %h required %h", f, i, rd_data, p[i]);
               end
            end
            do_ack();
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_sum();
      test_zero_len();
      test_bad_len();
      test_overrun();
      test_random();
      n_chk++;
      if (n_tmo !== 0) begin
         n_err++;
         $display("FAIL spurious_timeout: pulses=%0d required 0", n_tmo);
      end
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
